// File: rtl/shrink_game_pkg.sv
// Shared state encoding, default geometry and score constants for the shrinking-rectangle game.
// SHRINK_GAME_PAUSE_EN adds the PAUSE state and widens the state code to 3 bits.
package shrink_game_pkg;

`ifdef SHRINK_GAME_PAUSE_EN
  localparam int ST_W = 3;
`else
  localparam int ST_W = 2;
`endif

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 0,
    ST_RUN  = 1,
    ST_CALC = 2,
    ST_DONE = 3
`ifdef SHRINK_GAME_PAUSE_EN
    , ST_PAUSE = 4
`endif
  } state_t;

  localparam int INIT_HW_DEF      = 400;
  localparam int INIT_HH_DEF      = 300;
  localparam int MIN_HW_DEF       = 20;
  localparam int MIN_HH_DEF       = 15;
  localparam int SCORE_BASE_DEF   = 1000000;
  localparam int TIME_PENALTY_DEF = 1000;
  localparam int SCORE_GUARD      = 8;

  // Headroom so penalty plus areas cannot wrap before the clamp.
  function automatic int score_int_w(input int score_w);
    return score_w + SCORE_GUARD;
  endfunction

endpackage

// File: rtl/shrink_score_acc.sv
// Channel-serial score: acc = penalty*sec^2 + sum(4*hw*hh), score = base - acc clamped at 0.
// done rises N_CH+1 cycles after start and holds with the score until clr or the next start.
module shrink_score_acc
  import shrink_game_pkg::*;
#(
  parameter int N_CH         = 1,
  parameter int DIM_W        = 11,
  parameter int SCORE_W      = 32,
  parameter int SCORE_BASE   = SCORE_BASE_DEF,
  parameter int TIME_PENALTY = TIME_PENALTY_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    start,
  input  logic [7:0]              sec,
  input  logic [DIM_W*N_CH-1:0]   half_w,
  input  logic [DIM_W*N_CH-1:0]   half_h,
  output logic [SCORE_W-1:0]      score,
  output logic                    done
);

  localparam int ACC_W  = score_int_w(SCORE_W);
  localparam int AREA_W = 2*DIM_W + 2;
  localparam int IDX_W  = $clog2(N_CH + 1);
  localparam logic [ACC_W-1:0] BASE      = ACC_W'(SCORE_BASE);
  localparam logic [ACC_W-1:0] SCORE_MAX = ACC_W'((64'd1 << SCORE_W) - 64'd1);

  logic [ACC_W-1:0]  acc, penalty, diff;
  logic [ACC_W:0]    sum;
  logic [AREA_W-1:0] area;
  logic [IDX_W-1:0]  idx;
  logic              busy;
  logic [DIM_W-1:0]  cur_w, cur_h;

  always_comb begin
    cur_w = '0;
    cur_h = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(idx) == k) begin
        cur_w = half_w[k*DIM_W +: DIM_W];
        cur_h = half_h[k*DIM_W +: DIM_W];
      end
    end
    area    = (AREA_W'(cur_w) * AREA_W'(cur_h)) << 2;
    sum     = {1'b0, acc} + (ACC_W+1)'(area);
    penalty = ACC_W'(TIME_PENALTY) * ACC_W'(sec) * ACC_W'(sec);
    diff    = (acc >= BASE) ? '0 : BASE - acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; idx <= '0; busy <= 1'b0; done <= 1'b0; score <= '0;
    end else if (clr) begin
      acc <= '0; idx <= '0; busy <= 1'b0; done <= 1'b0; score <= '0;
    end else if (start) begin
      acc  <= penalty;
      idx  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (int'(idx) == N_CH) begin
        score <= SCORE_W'((diff > SCORE_MAX) ? SCORE_MAX : diff);
        done  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shrink_game_ctrl.sv
// Game controller: N_CH shrinking rectangles, seconds timer with limit, run/stop FSM, score.
// Dims/o_tick appear one cycle after prescaler wrap; score valid N_CH+2 cycles after stop; no backpressure.
// SHRINK_GAME_PAUSE_EN adds i_pause and the PAUSE state (o_state becomes 3 bits).
module shrink_game_ctrl
  import shrink_game_pkg::*;
#(
  parameter int N_CH         = 1,
  parameter int DIM_W        = 11,
  parameter int SCORE_W      = 32,
  parameter int TICK_CYCLES  = 200000,
  parameter int SEC_CYCLES   = 40000000,
  parameter int TIME_LIMIT   = 30,
  parameter int INIT_HW      = INIT_HW_DEF,
  parameter int INIT_HH      = INIT_HH_DEF,
  parameter int MIN_HW       = MIN_HW_DEF,
  parameter int MIN_HH       = MIN_HH_DEF,
  parameter int SCORE_BASE   = SCORE_BASE_DEF,
  parameter int TIME_PENALTY = TIME_PENALTY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_restart,
`ifdef SHRINK_GAME_PAUSE_EN
  input  logic                  i_pause,
`endif
  input  logic [4*N_CH-1:0]     i_step_w,
  input  logic [4*N_CH-1:0]     i_step_h,
  output logic [DIM_W*N_CH-1:0] o_half_w,
  output logic [DIM_W*N_CH-1:0] o_half_h,
  output logic [ST_W-1:0]       o_state,
  output logic [7:0]            o_seconds,
  output logic                  o_tick,
  output logic [SCORE_W-1:0]    o_score,
  output logic                  o_score_valid
);

  localparam int TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SC_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [TK_W-1:0]  TICK_LAST = TK_W'(TICK_CYCLES - 1);
  localparam logic [SC_W-1:0]  SEC_LAST  = SC_W'(SEC_CYCLES - 1);
  localparam logic [7:0]       LIMIT     = 8'(TIME_LIMIT);
  localparam logic [DIM_W-1:0] RLD_W = DIM_W'(INIT_HW);
  localparam logic [DIM_W-1:0] RLD_H = DIM_W'(INIT_HH);
  localparam logic [DIM_W-1:0] LO_W  = DIM_W'(MIN_HW);
  localparam logic [DIM_W-1:0] LO_H  = DIM_W'(MIN_HH);

  state_t             state;
  logic [DIM_W-1:0]   hw [N_CH];
  logic [DIM_W-1:0]   hh [N_CH];
  logic [TK_W-1:0]    tick_cnt;
  logic [SC_W-1:0]    sec_cnt;
  logic [7:0]         seconds, sec_nxt;
  logic               pause_req, in_pause, in_run, stop_req, advance;
  logic               tick_wrap, sec_wrap, limit_hit, go_calc, acc_start, acc_done;
  logic [SCORE_W-1:0] acc_score;

  function automatic logic [DIM_W-1:0] shrink(input logic [DIM_W-1:0] dim, input logic [3:0] step,
                                              input logic [DIM_W-1:0] rld, input logic [DIM_W-1:0] lo);
    if (dim <= lo) return rld;
    if (dim - lo <= DIM_W'(step)) return lo;
    return dim - DIM_W'(step);
  endfunction

`ifdef SHRINK_GAME_PAUSE_EN
  assign pause_req = i_pause;
  assign in_pause  = (state == ST_PAUSE);
`else
  assign pause_req = 1'b0;
  assign in_pause  = 1'b0;
`endif

  // A stop or pause in the wrap cycle suppresses that tick and second.
  always_comb begin
    in_run    = (state == ST_RUN);
    stop_req  = i_stop && (in_run || in_pause);
    advance   = in_run && !i_stop && !pause_req;
    tick_wrap = advance && (tick_cnt == TICK_LAST);
    sec_wrap  = advance && (sec_cnt == SEC_LAST);
    sec_nxt   = (sec_wrap && seconds < LIMIT) ? seconds + 8'd1 : seconds;
    limit_hit = advance && (sec_nxt >= LIMIT);
    go_calc   = stop_req || limit_hit;
    acc_start = go_calc && !i_restart;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE; tick_cnt <= '0; sec_cnt <= '0; seconds <= '0;
      o_tick <= 1'b0; o_score <= '0; o_score_valid <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin hw[k] <= RLD_W; hh[k] <= RLD_H; end
    end else if (i_restart) begin
      state <= ST_IDLE; tick_cnt <= '0; sec_cnt <= '0; seconds <= '0;
      o_tick <= 1'b0; o_score <= '0; o_score_valid <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin hw[k] <= RLD_W; hh[k] <= RLD_H; end
    end else begin
      o_tick <= tick_wrap;
      if (advance) begin
        tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
        sec_cnt  <= sec_wrap ? '0 : sec_cnt + 1'b1;
        seconds  <= sec_nxt;
        if (tick_wrap) begin
          for (int k = 0; k < N_CH; k++) begin
            hw[k] <= shrink(hw[k], i_step_w[4*k +: 4], RLD_W, LO_W);
            hh[k] <= shrink(hh[k], i_step_h[4*k +: 4], RLD_H, LO_H);
          end
        end
      end
      case (state)
        ST_IDLE: if (i_start) state <= ST_RUN;
        ST_RUN: begin
          if (go_calc) state <= ST_CALC;
`ifdef SHRINK_GAME_PAUSE_EN
          else if (pause_req) state <= ST_PAUSE;
`endif
        end
`ifdef SHRINK_GAME_PAUSE_EN
        ST_PAUSE: begin
          if (go_calc) state <= ST_CALC;
          else if (!i_pause) state <= ST_RUN;
        end
`endif
        ST_CALC: begin
          if (acc_done) begin
            state         <= ST_DONE;
            o_score       <= acc_score;
            o_score_valid <= 1'b1;
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_dims
    assign o_half_w[k*DIM_W +: DIM_W] = hw[k];
    assign o_half_h[k*DIM_W +: DIM_W] = hh[k];
  end

  assign o_state   = state;
  assign o_seconds = seconds;

  // Seconds seen by the accumulator include an increment landing on the CALC edge.
  shrink_score_acc #(
    .N_CH(N_CH), .DIM_W(DIM_W), .SCORE_W(SCORE_W),
    .SCORE_BASE(SCORE_BASE), .TIME_PENALTY(TIME_PENALTY)
  ) u_acc (
    .clk(clk), .rst_n(rst_n), .clr(i_restart), .start(acc_start), .sec(sec_nxt),
    .half_w(o_half_w), .half_h(o_half_h), .score(acc_score), .done(acc_done)
  );

endmodule
